// File: rtl/udp_csum_clear_pkg.sv
// Shared definitions for the UDP checksum-clear stage: frame offsets,
// header match constants, FSM encoding and the buffered beat payload.
package udp_csum_clear_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OFF_W  = 13;

  localparam logic [OFF_W-1:0] OFF_MAX      = '1;
  localparam logic [OFF_W-1:0] OFF_ETYPE_HI = 13'd12;
  localparam logic [OFF_W-1:0] OFF_ETYPE_LO = 13'd13;
  localparam logic [OFF_W-1:0] OFF_VER_IHL  = 13'd14;
  localparam logic [OFF_W-1:0] OFF_PROTO    = 13'd23;
  localparam logic [OFF_W-1:0] OFF_PORT_HI  = 13'd34;
  localparam logic [OFF_W-1:0] OFF_PORT_LO  = 13'd35;
  localparam logic [OFF_W-1:0] OFF_CSUM_HI  = 13'd40;
  localparam logic [OFF_W-1:0] OFF_CSUM_LO  = 13'd41;

  localparam logic [BYTE_W-1:0] ETYPE_HI   = 8'h08;
  localparam logic [BYTE_W-1:0] ETYPE_LO   = 8'h00;
  localparam logic [BYTE_W-1:0] VER_IHL    = 8'h45;
  localparam logic [BYTE_W-1:0] PROTO_UDP  = 8'h11;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_MOD  = 2'd1,
    ST_PASS = 2'd2
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
  } beat_t;

  // True when the byte at this offset satisfies its header criterion;
  // offsets that are not inspected always pass.
  function automatic logic hdr_byte_ok(input logic [OFF_W-1:0]  off,
                                       input logic [BYTE_W-1:0] data,
                                       input logic [15:0]       port);
    logic ok;
    ok = 1'b1;
    case (off)
      OFF_ETYPE_HI: ok = (data == ETYPE_HI);
      OFF_ETYPE_LO: ok = (data == ETYPE_LO);
      OFF_VER_IHL:  ok = (data == VER_IHL);
      OFF_PROTO:    ok = (data == PROTO_UDP);
      OFF_PORT_HI:  ok = (data == port[15:8]);
      OFF_PORT_LO:  ok = (data == port[7:0]);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/udp_csum_clear_if.sv
// Byte-stream bundle around the checksum-clear stage.
//   s_*: upstream side (data, valid, last in; ready out of the stage)
//   m_*: downstream side (data, valid, last out of the stage; ready in)
// master: the environment driving s_* and sinking m_*; slave: the stage.
interface udp_csum_clear_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/axis8_skid_buf.sv
// Two-entry registered buffer for byte+last beats.
//   in_beat/in_valid/in_ready  : upstream handshake, in_ready = not full (registered)
//   out_beat/out_valid/out_ready: downstream handshake, payload held in a register
// The output register is the head entry; the skid register absorbs one beat
// while the head is stalled.
module axis8_skid_buf
  import udp_csum_clear_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  beat_t in_beat,
  input  logic  in_valid,
  output logic  in_ready,
  output beat_t out_beat,
  output logic  out_valid,
  input  logic  out_ready
);

  beat_t out_beat_q, out_beat_d;
  beat_t skid_beat_q, skid_beat_d;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  in_ready_q, in_ready_d;
  logic  push_c, pop_c;

  assign push_c = in_valid & in_ready_q;
  assign pop_c  = out_valid_q & out_ready;

  // Next-state of the two entries.
  always_comb begin
    out_beat_d   = out_beat_q;
    out_valid_d  = out_valid_q;
    skid_beat_d  = skid_beat_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || pop_c) begin
      if (skid_valid_q) begin
        out_beat_d   = skid_beat_q;
        out_valid_d  = 1'b1;
        skid_valid_d = push_c;
        if (push_c) skid_beat_d = in_beat;
      end else begin
        out_valid_d = push_c;
        if (push_c) out_beat_d = in_beat;
      end
    end else if (push_c) begin
      skid_beat_d  = in_beat;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !(out_valid_d && skid_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_beat_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_beat_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_beat_q   <= out_beat_d;
      out_valid_q  <= out_valid_d;
      skid_beat_q  <= skid_beat_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_beat  = out_beat_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/udp_csum_clear.sv
// Clears the UDP checksum (offsets 40-41 -> 0x0000) of IPv4/UDP frames whose
// source port matches ctrl_reg, so frames altered upstream are not rejected.
//   clk, rst_n : clock, async active-low reset
//   ctrl_reg   : [16] enable, [15:0] port to match
//   bus        : s_* upstream stream in, m_* downstream stream out
//   pkt_count  : frames forwarded (counted on output last beats)
//   mod_count  : frames whose checksum was cleared
module udp_csum_clear
  import udp_csum_clear_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ctrl_reg,
  udp_csum_clear_if.slave      bus,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [CNT_W-1:0]     mod_count
);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0]  mod_count_q, mod_count_d;

  logic              s_ready_c;
  logic              push_c, pop_c;
  logic              match_now_c;
  logic              zero_c;
  beat_t             in_beat_c, out_beat_c;
  logic              out_valid_c;
  logic              unused_ctrl_c;

  assign unused_ctrl_c = ^ctrl_reg[31:17];

  assign push_c = bus.s_valid & s_ready_c;
  assign pop_c  = out_valid_c & bus.m_ready;

  // Running header match; offset 0 restarts it, offset 35 folds in the enable.
  assign match_now_c = ((off_q == '0) ? 1'b1 : match_q)
                     & hdr_byte_ok(off_q, bus.s_data, ctrl_reg[15:0])
                     & ((off_q != OFF_PORT_LO) | ctrl_reg[16]);

  // Offset 40 is left intact when it ends the frame (runt).
  assign zero_c = (state_q == ST_MOD)
                & (((off_q == OFF_CSUM_HI) & ~bus.s_last) | (off_q == OFF_CSUM_LO));

  always_comb begin
    in_beat_c      = '0;
    in_beat_c.data = zero_c ? '0 : bus.s_data;
    in_beat_c.last = bus.s_last;
  end

  // Parser FSM, offset counter and statistics.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    match_d     = match_q;
    pkt_count_d = pkt_count_q;
    mod_count_d = mod_count_q;
    if (push_c) begin
      match_d = match_now_c;
      if (bus.s_last)             off_d = '0;
      else if (off_q != OFF_MAX)  off_d = off_q + OFF_W'(1);
      case (state_q)
        ST_HDR: begin
          if (off_q == OFF_PORT_LO) state_d = match_now_c ? ST_MOD : ST_PASS;
        end
        ST_MOD: begin
          if (off_q == OFF_CSUM_LO) begin
            state_d     = ST_PASS;
            mod_count_d = mod_count_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (bus.s_last) state_d = ST_HDR;
    end
    if (pop_c && out_beat_c.last) pkt_count_d = pkt_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HDR;
      off_q       <= '0;
      match_q     <= 1'b0;
      pkt_count_q <= '0;
      mod_count_q <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      match_q     <= match_d;
      pkt_count_q <= pkt_count_d;
      mod_count_q <= mod_count_d;
    end
  end

  axis8_skid_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_beat   (in_beat_c),
    .in_valid  (bus.s_valid),
    .in_ready  (s_ready_c),
    .out_beat  (out_beat_c),
    .out_valid (out_valid_c),
    .out_ready (bus.m_ready)
  );

  assign bus.s_ready = s_ready_c;
  assign bus.m_data  = out_beat_c.data;
  assign bus.m_last  = out_beat_c.last;
  assign bus.m_valid = out_valid_c;
  assign pkt_count   = pkt_count_q;
  assign mod_count   = mod_count_q;

endmodule

// File: tb/tb_udp_csum_clear.sv
// Directed bench for udp_csum_clear: frame patterns with expected outputs
// built by the bench, stream monitor on the falling edge.
module tb_udp_csum_clear;

  typedef logic [7:0] bq_t[$];
  typedef bit         bl_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl_reg;
  logic [31:0] pkt_count, mod_count;

  udp_csum_clear_if bus();

  udp_csum_clear #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl_reg  (ctrl_reg),
    .bus       (bus),
    .pkt_count (pkt_count),
    .mod_count (mod_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_pkt = 0;
  int exp_mod = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  bq_t  out_d;
  bl_t  out_l;
  int   out_c[$];
  int   in_c[$];
  int   in_hs = 0, out_hs = 0;
  bit   mr_rand = 0, chk_ready = 0;
  int   stall_viol = 0, ready_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic prev_last = 1'b0;

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_hs = 0; out_hs = 0; prev_stall = 1'b0;
      end else begin
        if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last))
          stall_viol++;
        if (chk_ready && (bus.s_ready !== ((in_hs - out_hs) != 2))) ready_viol++;
        if (bus.s_valid && bus.s_ready) begin
          in_hs++; in_c.push_back(cyc);
        end
        if (bus.m_valid && bus.m_ready) begin
          out_hs++;
          out_d.push_back(bus.m_data); out_l.push_back(bus.m_last); out_c.push_back(cyc);
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
      end
    end
  end

  function automatic bq_t mk_frame(int len, logic [7:0] proto, logic [15:0] port);
    bq_t f;
    for (int i = 0; i < len; i++) f.push_back(8'(i * 37 + 11));
    if (len > 12) f[12] = 8'h08;
    if (len > 13) f[13] = 8'h00;
    if (len > 14) f[14] = 8'h45;
    if (len > 23) f[23] = proto;
    if (len > 34) f[34] = port[15:8];
    if (len > 35) f[35] = port[7:0];
    if (len > 40) f[40] = 8'hA5;
    if (len > 41) f[41] = 8'h5A;
    return f;
  endfunction

  function automatic bq_t exp_frame(bq_t f, bit clr);
    bq_t e;
    e = f;
    if (clr && e.size() > 41) begin
      e[40] = 8'h00;
      e[41] = 8'h00;
    end
    return e;
  endfunction

  function automatic bl_t mk_last(int len);
    bl_t l;
    for (int i = 0; i < len; i++) l.push_back(i == len - 1);
    return l;
  endfunction

  task automatic clear_mon();
    out_d.delete(); out_l.delete(); out_c.delete(); in_c.delete();
  endtask

  task automatic send(input bq_t d, input bl_t l);
    for (int i = 0; i < d.size(); i++) begin
      int guard;
      bit acc;
      bus.s_valid = 1'b1;
      bus.s_data  = d[i];
      bus.s_last  = l[i];
      guard = 0;
      acc   = 1'b0;
      while (!acc) begin
        acc = bus.s_ready;
        @(posedge clk);
        #1;
        guard++;
        if (!acc && guard > 200) begin
          total++; bad++;
          $display("FAIL send_timeout byte=%0d s_ready got 0 expected 1", i);
          bus.s_valid = 1'b0;
          return;
        end
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_out(int n);
    int g;
    g = 0;
    while (out_d.size() < n && g < 600) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ctrl_reg = 32'h0; bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got %b expected 0", bus.m_valid); end
    total++; if (bus.m_data !== 8'h00) begin bad++; $display("FAIL rst_m_data got %h expected 00", bus.m_data); end
    total++; if (bus.m_last !== 1'b0) begin bad++; $display("FAIL rst_m_last got %b expected 0", bus.m_last); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got %b expected 0", bus.s_ready); end
    total++; if (pkt_count !== 32'd0) begin bad++; $display("FAIL rst_pkt got %0d expected 0", pkt_count); end
    total++; if (mod_count !== 32'd0) begin bad++; $display("FAIL rst_mod got %0d expected 0", mod_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL rel_s_ready_early got %b expected 0", bus.s_ready); end
    @(posedge clk);
    #1;
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rel_s_ready got %b expected 1", bus.s_ready); end
  endtask

  task automatic test_match();
    bq_t f, e;
    bl_t el;
    ctrl_reg = 32'h0001_1234;
    clear_mon();
    f  = mk_frame(60, 8'h11, 16'h1234);
    e  = exp_frame(f, 1'b1);
    el = mk_last(60);
    send(f, el);
    wait_out(60);
    exp_pkt += 1; exp_mod += 1;
    total++; if (out_d.size() !== 60) begin bad++; $display("FAIL match_len got %0d expected 60", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 60; i++) begin
      total++;
      if (out_d[i] !== e[i] || out_l[i] !== el[i]) begin
        bad++; $display("FAIL match_byte[%0d] got %h/%b expected %h/%b", i, out_d[i], out_l[i], e[i], el[i]);
      end
    end
    if (out_c.size() == 60 && in_c.size() == 60) begin
      total++; if (out_c[0] - in_c[0] !== 1) begin bad++; $display("FAIL match_lat_first got %0d expected 1", out_c[0] - in_c[0]); end
      total++; if (out_c[59] - in_c[59] !== 1) begin bad++; $display("FAIL match_lat_last got %0d expected 1", out_c[59] - in_c[59]); end
    end
    total++; if (mod_count !== 32'(exp_mod)) begin bad++; $display("FAIL match_mod got %0d expected %0d", mod_count, exp_mod); end
    total++; if (pkt_count !== 32'(exp_pkt)) begin bad++; $display("FAIL match_pkt got %0d expected %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_disabled();
    bq_t f;
    bl_t el;
    for (int k = 0; k < 2; k++) begin
      ctrl_reg = (k == 0) ? 32'h0000_1234 : 32'h0001_1235;
      clear_mon();
      f  = mk_frame(60, 8'h11, 16'h1234);
      el = mk_last(60);
      send(f, el);
      wait_out(60);
      exp_pkt += 1;
      total++; if (out_d.size() !== 60) begin bad++; $display("FAIL dis%0d_len got %0d expected 60", k, out_d.size()); end
      for (int i = 0; i < out_d.size() && i < 60; i++) begin
        total++;
        if (out_d[i] !== f[i] || out_l[i] !== el[i]) begin
          bad++; $display("FAIL dis%0d_byte[%0d] got %h/%b expected %h/%b", k, i, out_d[i], out_l[i], f[i], el[i]);
        end
      end
    end
    total++; if (mod_count !== 32'(exp_mod)) begin bad++; $display("FAIL dis_mod got %0d expected %0d", mod_count, exp_mod); end
    total++; if (pkt_count !== 32'(exp_pkt)) begin bad++; $display("FAIL dis_pkt got %0d expected %0d", pkt_count, exp_pkt); end
  endtask

  // TCP frame, runts of 30 and 41 bytes, a 42-byte frame ending on offset 41,
  // then a full matching frame.
  task automatic test_tcp_runt();
    bq_t f, e;
    bl_t el, l;
    int  lens[5]  = '{60, 30, 41, 42, 60};
    bit  clrs[5]  = '{0, 0, 0, 1, 1};
    ctrl_reg = 32'h0001_1234;
    clear_mon();
    e.delete(); el.delete();
    for (int k = 0; k < 5; k++) begin
      bq_t x;
      f = mk_frame(lens[k], (k == 0) ? 8'h06 : 8'h11, 16'h1234);
      l = mk_last(lens[k]);
      x = exp_frame(f, clrs[k]);
      foreach (x[i]) begin e.push_back(x[i]); el.push_back(l[i]); end
      send(f, l);
      @(posedge clk);
      #1;
    end
    wait_out(e.size());
    exp_pkt += 5; exp_mod += 2;
    total++; if (out_d.size() !== e.size()) begin bad++; $display("FAIL runt_len got %0d expected %0d", out_d.size(), e.size()); end
    for (int i = 0; i < out_d.size() && i < e.size(); i++) begin
      total++;
      if (out_d[i] !== e[i] || out_l[i] !== el[i]) begin
        bad++; $display("FAIL runt_byte[%0d] got %h/%b expected %h/%b", i, out_d[i], out_l[i], e[i], el[i]);
      end
    end
    total++; if (mod_count !== 32'(exp_mod)) begin bad++; $display("FAIL runt_mod got %0d expected %0d", mod_count, exp_mod); end
    total++; if (pkt_count !== 32'(exp_pkt)) begin bad++; $display("FAIL runt_pkt got %0d expected %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_backpressure();
    bq_t f, e;
    bl_t el;
    ctrl_reg = 32'h0001_1234;
    clear_mon();
    stall_viol = 0; ready_viol = 0;
    mr_rand = 1'b1; chk_ready = 1'b1;
    f  = mk_frame(60, 8'h11, 16'h1234);
    e  = exp_frame(f, 1'b1);
    el = mk_last(60);
    send(f, el);
    wait_out(60);
    mr_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_ready = 1'b0;
    exp_pkt += 1; exp_mod += 1;
    total++; if (out_d.size() !== 60) begin bad++; $display("FAIL bp_len got %0d expected 60", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 60; i++) begin
      total++;
      if (out_d[i] !== e[i] || out_l[i] !== el[i]) begin
        bad++; $display("FAIL bp_byte[%0d] got %h/%b expected %h/%b", i, out_d[i], out_l[i], e[i], el[i]);
      end
    end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL bp_stall_stable got %0d events expected 0", stall_viol); end
    total++; if (ready_viol !== 0) begin bad++; $display("FAIL bp_ready_vs_full got %0d events expected 0", ready_viol); end
    total++; if (mod_count !== 32'(exp_mod)) begin bad++; $display("FAIL bp_mod got %0d expected %0d", mod_count, exp_mod); end
    total++; if (pkt_count !== 32'(exp_pkt)) begin bad++; $display("FAIL bp_pkt got %0d expected %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_reset_mid();
    bq_t f, part, e;
    bl_t el, pl;
    ctrl_reg = 32'h0001_1234;
    clear_mon();
    f = mk_frame(60, 8'h11, 16'h1234);
    for (int i = 0; i <= 38; i++) begin part.push_back(f[i]); pl.push_back(1'b0); end
    send(part, pl);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid got %b expected 0", bus.m_valid); end
    total++; if (bus.m_data !== 8'h00) begin bad++; $display("FAIL mid_m_data got %h expected 00", bus.m_data); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL mid_s_ready got %b expected 0", bus.s_ready); end
    total++; if (pkt_count !== 32'd0) begin bad++; $display("FAIL mid_pkt got %0d expected 0", pkt_count); end
    total++; if (mod_count !== 32'd0) begin bad++; $display("FAIL mid_mod got %0d expected 0", mod_count); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    exp_pkt = 1; exp_mod = 1;
    e  = exp_frame(f, 1'b1);
    el = mk_last(60);
    send(f, el);
    wait_out(60);
    total++; if (out_d.size() !== 60) begin bad++; $display("FAIL mid_len got %0d expected 60", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 60; i++) begin
      total++;
      if (out_d[i] !== e[i] || out_l[i] !== el[i]) begin
        bad++; $display("FAIL mid_byte[%0d] got %h/%b expected %h/%b", i, out_d[i], out_l[i], e[i], el[i]);
      end
    end
    total++; if (mod_count !== 32'(exp_mod)) begin bad++; $display("FAIL mid_mod_after got %0d expected %0d", mod_count, exp_mod); end
    total++; if (pkt_count !== 32'(exp_pkt)) begin bad++; $display("FAIL mid_pkt_after got %0d expected %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_back_to_back();
    bq_t d, e;
    bl_t l;
    ctrl_reg = 32'h0001_1234;
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      bq_t f, x;
      bl_t fl;
      f  = mk_frame(60, (k == 1) ? 8'h06 : 8'h11, 16'h1234);
      x  = exp_frame(f, k != 1);
      fl = mk_last(60);
      foreach (f[i]) begin d.push_back(f[i]); e.push_back(x[i]); l.push_back(fl[i]); end
    end
    send(d, l);
    wait_out(180);
    exp_pkt += 3; exp_mod += 2;
    total++; if (out_d.size() !== 180) begin bad++; $display("FAIL b2b_len got %0d expected 180", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 180; i++) begin
      total++;
      if (out_d[i] !== e[i] || out_l[i] !== l[i]) begin
        bad++; $display("FAIL b2b_byte[%0d] got %h/%b expected %h/%b", i, out_d[i], out_l[i], e[i], l[i]);
      end
    end
    if (in_c.size() == 180 && out_c.size() == 180) begin
      total++; if (in_c[179] - in_c[0] !== 179) begin bad++; $display("FAIL b2b_in_gap got span %0d expected 179", in_c[179] - in_c[0]); end
      total++; if (out_c[179] - out_c[0] !== 179) begin bad++; $display("FAIL b2b_out_gap got span %0d expected 179", out_c[179] - out_c[0]); end
    end
    total++; if (mod_count !== 32'(exp_mod)) begin bad++; $display("FAIL b2b_mod got %0d expected %0d", mod_count, exp_mod); end
    total++; if (pkt_count !== 32'(exp_pkt)) begin bad++; $display("FAIL b2b_pkt got %0d expected %0d", pkt_count, exp_pkt); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_disabled();
    test_tcp_runt();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
